alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the team's combinational 32-bit ALU. Keeps the 4-bit `aluc` operation set and the zero/carry/negative/overflow flags, generalised to `WIDTH` bits. Adds registered valid/ready input and output channels and two iterative multi-cycle ops, unsigned multiply and unsigned divide, that produce a double-width result. Sits between the decode/operand stage and writeback of the datapath.

## Interface
- `WIDTH`, 32, operand/result width; even, ≥ 4.
- `SHW`, `$clog2(WIDTH)`, shift-amount width; derived, not overridden.
- `clk` input 1 — rising-edge clock.
- `rst_n` input 1 — reset, asynchronous, active-low.
- `in_valid` input 1 — operation offered.
- `in_ready` output 1 — operation accepted this cycle when high with `in_valid`.
- `op` input 5 — `op[4]`=0: legacy `aluc` in `op[3:0]`; `op[4]`=1: extended op.
- `a`, `b` input `WIDTH` — operands.
- `out_valid` output 1 — result registers hold an undelivered result.
- `out_ready` input 1 — consumer takes result.
- `r` output `WIDTH` — primary result (product low half / quotient).
- `rh` output `WIDTH` — product high half / remainder; 0 for legacy ops.
- `zero`, `carry`, `negative`, `overflow` output 1 — flags registered with `r`.

## Operation
- Legacy codes (`op[4]`=0):
  - 0000 ADDU, 0010 ADD: a+b.
  - 0001 SUBU, 0011 SUB: a−b.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR.
  - 100x LUI: b << WIDTH/2.
  - 1011 SLT (signed), 1010 SLTU: r = (a<b) ? 1 : 0.
  - 1100 SRA, 1101 SRL, 111x SLL: b shifted by `a[SHW-1:0]`.
- Extended codes: 10000 MULU, {rh,r} = a×b unsigned. 10001 DIVU, r = a/b, rh = a%b. Codes 10010–11111: r = rh = 0, all flags 0, single-cycle.
- Flags:
  - `zero` = (r==0) for every op.
  - `negative` = r[WIDTH-1`]`, except SLT, where it equals the signed a<b.
  - `carry`:
    - ADDU/ADD: carry-out.
    - SUBU/SUB/SLTU: unsigned borrow (a<b).
    - Shifts: last bit shifted out; 0 when the amount is 0.
    - All other ops: 0.
  - `overflow`:
    - ADD/SUB: signed overflow.
    - MULU: rh≠0.
    - DIVU: b==0.
    - All other ops: 0.
- DIVU with b==0: r = all ones, rh = a, overflow=1. Runs the full iteration count.
- FSM states:
  - IDLE: accept; legacy op → IDLE with result loaded; MULU/DIVU → ITER.
  - ITER: one shift-add / restoring-subtract step per cycle; counter WIDTH−1 down to 0; at 0 → DONE.
  - DONE: load result into output registers → IDLE.

## Timing
- Reset: `out_valid`=0, `r`=`rh`=0, all flags 0, FSM=IDLE, counter=0, `in_ready` then 1.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready). It is combinational from state and `out_ready` only, never from `in_valid`.
- Legacy op accepted at edge N: `out_valid`=1 with result after edge N (latency 1). Back-to-back throughput is one per cycle while `out_ready`=1.
- MULU/DIVU accepted at edge N: result valid after edge N+WIDTH+1. `in_ready`=0 from edge N to the result edge.
- Output registers and flags hold stable while `out_valid && !out_ready`. `out_valid` drops on the delivery edge unless a new result loads on the same edge.
- Simultaneous delivery and acceptance: the new legacy result replaces the old in one edge; `out_valid` stays 1.
- DONE with `out_valid && !out_ready`: FSM stalls in DONE until the output slot frees.
- Operands are latched at acceptance; changes on `a`/`b`/`op` during ITER are ignored.
- `rst_n` low mid-iteration: the operation is abandoned immediately, all outputs go to reset values, and no result is ever presented.

## Structure
- `alu_pkg`: 5-bit op encodings (ALU_ADDU … ALU_DIVU), FSM state enum {IDLE, ITER, DONE}.
- Sub-module `alu_muldiv_iter`:
  - Holds the accumulator/remainder, operand shift registers and iteration counter.
  - Ports: start, is_div, a, b → done pulse, lo, hi.
- The combinational legacy datapath is a function or `always_comb` block in the top level.

## Test plan
- WIDTH=32, SLL, a=0x10, b=0x80000000 → after 1 cycle r=0, zero=1, carry=0, negative=0, overflow=0.
- ADD a=0x7FFFFFFF, b=1 → r=0x80000000, overflow=1, negative=1, carry=0. ADDU same operands → overflow=0.
- SUBU a=1, b=2 → r=0xFFFFFFFF, carry=1. SLT a=0xFFFFFFFF, b=1 → r=1. SLTU same operands → r=0.
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF → r=0x00000001, rh=0xFFFFFFFE, overflow=1, `out_valid` exactly 33 cycles after acceptance, `in_ready`=0 throughout.
- DIVU a=100, b=7 → r=14, rh=2. DIVU b=0, a=5 → r=0xFFFFFFFF, rh=5, overflow=1.
- Hold `out_ready`=0 with three legacy ops offered → only the first accepted and the outputs stable. Assert `rst_n`=0 mid-MULU → `out_valid`=0 immediately, and the next op completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 5-bit operation encodings. op[4]=0 selects the legacy aluc set in op[3:0];
//     op[4]=1 selects the extended set (MULU, DIVU, the rest reserved).
//   - FSM state enum for the top-level controller.
//   - is_multicycle(): true for the ops routed through the iterative unit.
package alu_pkg;

  // Legacy aluc codes, zero-extended to 5 bits.
  localparam logic [4:0] ALU_ADDU    = 5'b00000;
  localparam logic [4:0] ALU_SUBU    = 5'b00001;
  localparam logic [4:0] ALU_ADD     = 5'b00010;
  localparam logic [4:0] ALU_SUB     = 5'b00011;
  localparam logic [4:0] ALU_AND     = 5'b00100;
  localparam logic [4:0] ALU_OR      = 5'b00101;
  localparam logic [4:0] ALU_XOR     = 5'b00110;
  localparam logic [4:0] ALU_NOR     = 5'b00111;
  localparam logic [4:0] ALU_LUI     = 5'b01000;
  localparam logic [4:0] ALU_LUI_ALT = 5'b01001;
  localparam logic [4:0] ALU_SLTU    = 5'b01010;
  localparam logic [4:0] ALU_SLT     = 5'b01011;
  localparam logic [4:0] ALU_SRA     = 5'b01100;
  localparam logic [4:0] ALU_SRL     = 5'b01101;
  localparam logic [4:0] ALU_SLL     = 5'b01110;
  localparam logic [4:0] ALU_SLL_ALT = 5'b01111;

  // Extended codes. 10010..11111 are reserved and produce an all-zero result.
  localparam logic [4:0] ALU_MULU    = 5'b10000;
  localparam logic [4:0] ALU_DIVU    = 5'b10001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_multicycle(input logic [4:0] op_code);
    return (op_code == ALU_MULU) || (op_code == ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative unsigned multiply / restoring divide.
//   One step per clock, WIDTH steps per operation, counter runs WIDTH-1 .. 0.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - load operands and begin (ignored by design while busy;
//                  the controller never issues it then)
//   is_div       - 1: divide a/b, 0: multiply a*b (sampled with start)
//   a, b         - operands (sampled with start)
//   done         - high during the final step; lo/hi are final after that edge
//   lo, hi       - multiply: product low/high half; divide: quotient/remainder
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic             div_q, div_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;   // multiply accumulator / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;   // multiplier bits / dividend-then-quotient
  logic [WIDTH-1:0] m_q, m_d;     // multiplicand / divisor

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;

  always_comb begin
    add_sum   = {1'b0, hi_q} + {1'b0, m_q};
    // Restoring divide: bring in the next dividend bit, trial-subtract.
    // rem_shift < 2*divisor always, so a non-negative difference fits in
    // WIDTH bits and bit WIDTH of rem_diff is exactly the borrow.
    rem_shift = {hi_q, lo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, m_q};

    busy_d = busy_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    m_d    = m_q;

    if (start) begin
      busy_d = 1'b1;
      div_d  = is_div;
      cnt_d  = CNT_INIT;
      hi_d   = '0;
      lo_d   = a;
      m_d    = b;
    end else if (busy_q) begin
      if (div_q) begin
        if (!rem_diff[WIDTH]) begin
          hi_d = rem_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = rem_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        // Shift-add: the multiplier drains out of lo from the bottom while
        // product bits enter at the top.
        if (lo_q[0]) begin
          {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end
      end
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      m_q    <= m_d;
    end
  end

  assign done = busy_q && (cnt_q == '0);
  assign lo   = lo_q;
  assign hi   = hi_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with legacy aluc ops (1-cycle) and
// iterative unsigned MULU/DIVU (WIDTH+1 cycles), double-width result.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - operation channel (op, a, b)
//   op                    - op[4]=0 legacy aluc in op[3:0], op[4]=1 extended
//   a, b                  - operands, latched at acceptance
//   out_valid / out_ready - result channel (r, rh, flags)
//   r, rh                 - result / product-high or remainder (0 for legacy)
//   zero, carry, negative, overflow - flags registered with r
//   dbg_state_o           - controller state (alu_pkg::state_e encoding)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_valid/out_valid never wait on ready. in_ready depends only on
// controller state, out_valid and out_ready (never on in_valid). Once
// out_valid is high, r/rh/flags hold until the edge that transfers them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] rh,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic [1:0]       dbg_state_o
);

  localparam int SHW = $clog2(WIDTH);

  // ---------------------------------------------------------------------
  // Legacy / single-cycle datapath
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH:0]   srl_ext;
  logic [WIDTH:0]   sra_ext;
  logic [WIDTH:0]   sll_ext;
  logic [SHW-1:0]   shamt;
  logic             slt_signed;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] leg_r;
  logic             leg_z;
  logic             leg_c;
  logic             leg_n;
  logic             leg_v;

  always_comb begin
    shamt      = a[SHW-1:0];
    add_ext    = {1'b0, a} + {1'b0, b};
    // Bit WIDTH of the zero-extended difference is the unsigned borrow (a<b).
    sub_ext    = {1'b0, a} - {1'b0, b};
    // Shifts carry one guard bit so the last bit shifted out lands in a
    // fixed position; a zero shift leaves the guard at 0, giving carry=0.
    srl_ext    = {b, 1'b0} >> shamt;
    sra_ext    = $signed({b, 1'b0}) >>> shamt;
    sll_ext    = {1'b0, b} << shamt;
    slt_signed = $signed(a) < $signed(b);
    add_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
    sub_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);

    leg_r = '0;
    leg_c = 1'b0;
    leg_v = 1'b0;
    case (op)
      ALU_ADDU: begin
        leg_r = add_ext[WIDTH-1:0];
        leg_c = add_ext[WIDTH];
      end
      ALU_ADD: begin
        leg_r = add_ext[WIDTH-1:0];
        leg_c = add_ext[WIDTH];
        leg_v = add_ovf;
      end
      ALU_SUBU: begin
        leg_r = sub_ext[WIDTH-1:0];
        leg_c = sub_ext[WIDTH];
      end
      ALU_SUB: begin
        leg_r = sub_ext[WIDTH-1:0];
        leg_c = sub_ext[WIDTH];
        leg_v = sub_ovf;
      end
      ALU_AND: leg_r = a & b;
      ALU_OR:  leg_r = a | b;
      ALU_XOR: leg_r = a ^ b;
      ALU_NOR: leg_r = ~(a | b);
      ALU_LUI, ALU_LUI_ALT: begin
        leg_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      end
      ALU_SLTU: begin
        leg_r = {{(WIDTH-1){1'b0}}, sub_ext[WIDTH]};
        leg_c = sub_ext[WIDTH];
      end
      ALU_SLT: leg_r = {{(WIDTH-1){1'b0}}, slt_signed};
      ALU_SRA: begin
        leg_r = sra_ext[WIDTH:1];
        leg_c = sra_ext[0];
      end
      ALU_SRL: begin
        leg_r = srl_ext[WIDTH:1];
        leg_c = srl_ext[0];
      end
      ALU_SLL, ALU_SLL_ALT: begin
        leg_r = sll_ext[WIDTH-1:0];
        leg_c = sll_ext[WIDTH];
      end
      default: ; // reserved extended codes: everything stays 0
    endcase
    // Reserved extended codes report all flags 0, including zero.
    leg_z = !op[4] && (leg_r == '0);
    leg_n = (op == ALU_SLT) ? slt_signed : leg_r[WIDTH-1];
  end

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] rh_q, rh_d;
  logic [3:0]       flags_q, flags_d;   // {zero, carry, negative, overflow}
  logic             is_div_q, is_div_d;
  logic             div_zero_q, div_zero_d;

  logic             slot_free;
  logic             accept;
  logic             is_md;
  logic             start;
  logic             load_leg;
  logic             load_md;
  logic             md_done;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;

  // The output slot can take a new result if empty or being drained now.
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;
  assign is_md     = is_multicycle(op);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_md) state_d = ITER;
      ITER: if (md_done) state_d = DONE;
      DONE: if (slot_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    start    = 1'b0;
    load_leg = 1'b0;
    load_md  = 1'b0;
    case (state_q)
      IDLE: begin
        start    = accept && is_md;
        load_leg = accept && !is_md;
      end
      DONE:    load_md = slot_free;
      default: ;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .is_div (op == ALU_DIVU),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  // Result and side-band registers
  always_comb begin
    out_valid_d = out_valid_q;
    r_d         = r_q;
    rh_d        = rh_q;
    flags_d     = flags_q;
    is_div_d    = is_div_q;
    div_zero_d  = div_zero_q;

    if (start) begin
      is_div_d   = (op == ALU_DIVU);
      div_zero_d = (b == '0);
    end

    if (load_leg) begin
      out_valid_d = 1'b1;
      r_d         = leg_r;
      rh_d        = '0;
      flags_d     = {leg_z, leg_c, leg_n, leg_v};
    end else if (load_md) begin
      out_valid_d = 1'b1;
      r_d         = md_lo;
      rh_d        = md_hi;
      flags_d     = {md_lo == '0, 1'b0, md_lo[WIDTH-1],
                     is_div_q ? div_zero_q : (md_hi != '0)};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
      rh_q        <= '0;
      flags_q     <= '0;
      is_div_q    <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      rh_q        <= rh_d;
      flags_q     <= flags_d;
      is_div_q    <= is_div_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign r           = r_q;
  assign rh          = rh_q;
  assign zero        = flags_q[3];
  assign carry       = flags_q[2];
  assign negative    = flags_q[1];
  assign overflow    = flags_q[0];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=32).
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int EW = 2 * W + 4;   // {rh, zero, carry, negative, overflow, r}

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic [W-1:0] rh;
  logic         zero;
  logic         carry;
  logic         negative;
  logic         overflow;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [4:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [EW-1:0] exp;
    int            lat;
  } dvec_t;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .r           (r),
    .rh          (rh),
    .zero        (zero),
    .carry       (carry),
    .negative    (negative),
    .overflow    (overflow),
    .dbg_state_o (dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] pk(input logic [W-1:0] xh, input logic z,
                                       input logic c, input logic n,
                                       input logic v, input logic [W-1:0] x);
    return {xh, z, c, n, v, x};
  endfunction

  function automatic logic [EW-1:0] got_now();
    return {rh, zero, carry, negative, overflow, r};
  endfunction

  // Behavioural model straight from the operation table, using wide integer
  // arithmetic rather than bit-level datapath structure.
  function automatic logic [EW-1:0] model(input logic [4:0] o,
                                          input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [W-1:0] er, erh;
    logic         ez, ec, en, ev;
    longint       sx, sy, s;
    logic [63:0]  p;
    int           sh;
    sx = $signed(x);
    sy = $signed(y);
    sh = int'(x[4:0]);
    er = '0; erh = '0; ec = 1'b0; ev = 1'b0;
    case (o)
      5'd0, 5'd2: begin
        p  = 64'(x) + 64'(y);
        er = p[31:0];
        ec = p[32];
        s  = sx + sy;
        if (o == 5'd2) ev = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd1, 5'd3: begin
        er = x - y;
        ec = (x < y);
        s  = sx - sy;
        if (o == 5'd3) ev = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd4: er = x & y;
      5'd5: er = x | y;
      5'd6: er = x ^ y;
      5'd7: er = ~(x | y);
      5'd8, 5'd9: er = y << 16;
      5'd10: begin er = (x < y) ? 1 : 0; ec = (x < y); end
      5'd11: er = (sx < sy) ? 1 : 0;
      5'd12: begin er = 32'(sy >>> sh); ec = (sh == 0) ? 1'b0 : y[sh-1]; end
      5'd13: begin er = y >> sh;        ec = (sh == 0) ? 1'b0 : y[sh-1]; end
      5'd14, 5'd15: begin er = y << sh; ec = (sh == 0) ? 1'b0 : y[32-sh]; end
      5'd16: begin
        p   = 64'(x) * 64'(y);
        er  = p[31:0];
        erh = p[63:32];
        ev  = (erh != 0);
      end
      5'd17: begin
        if (y == 0) begin er = '1; erh = x; ev = 1'b1; end
        else begin er = x / y; erh = x % y; end
      end
      default: ;
    endcase
    ez = (er == 0) && (o < 5'd18);
    en = (o == 5'd11) ? (sx < sy) : er[31];
    return pk(erh, ez, ec, en, ev, er);
  endfunction

  function automatic logic [4:0] rand_op();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7)  return 5'($urandom_range(0, 15));
    if (k == 7) return ALU_MULU;
    if (k == 8) return ALU_DIVU;
    return 5'($urandom_range(18, 31));
  endfunction

  // ---------------- driver tasks ----------------
  // Offers one op with out_ready=1, waits for acceptance, scrambles the
  // inputs, then waits for the result. lat = edges after the accept edge.
  task automatic run_op(input logic [4:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, output logic [EW-1:0] got,
                        output int lat, output int ir_hi, output bit to);
    int n;
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1; to = 1'b0; n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) to = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
    lat = 0; ir_hi = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ir_hi++;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) to = 1'b1;
    got = got_now();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({out_valid, got_now()} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {out_valid, got_now()});
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    n_tests++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    dvec_t tv[12];
    logic [EW-1:0] got;
    int lat, ir_hi;
    bit to;
    tv[0]  = '{ALU_SLL,  32'h10,       32'h80000000, pk(0, 1, 0, 0, 0, 32'h0), 0};
    tv[1]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h1,        pk(0, 0, 0, 1, 1, 32'h80000000), 0};
    tv[2]  = '{ALU_ADDU, 32'h7FFFFFFF, 32'h1,        pk(0, 0, 0, 1, 0, 32'h80000000), 0};
    tv[3]  = '{ALU_SUBU, 32'h1,        32'h2,        pk(0, 0, 1, 1, 0, 32'hFFFFFFFF), 0};
    tv[4]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h1,        pk(0, 0, 0, 1, 0, 32'h1), 0};
    tv[5]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h1,        pk(0, 1, 0, 0, 0, 32'h0), 0};
    tv[6]  = '{ALU_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, pk(32'hFFFFFFFE, 0, 0, 0, 1, 32'h1), 33};
    tv[7]  = '{ALU_DIVU, 32'd100,      32'd7,        pk(32'd2, 0, 0, 0, 0, 32'd14), 33};
    tv[8]  = '{ALU_DIVU, 32'd5,        32'd0,        pk(32'd5, 0, 0, 1, 1, 32'hFFFFFFFF), 33};
    tv[9]  = '{ALU_SRA,  32'd4,        32'h80000018, pk(0, 0, 1, 1, 0, 32'hF8000001), 0};
    tv[10] = '{ALU_SRL,  32'd0,        32'd5,        pk(0, 0, 0, 0, 0, 32'd5), 0};
    tv[11] = '{5'b10101, 32'd0,        32'd0,        pk(0, 0, 0, 0, 0, 32'd0), 0};
    for (int i = 0; i < 12; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, got, lat, ir_hi, to);
      n_tests++;
      if (got !== tv[i].exp || to) begin
        n_fail++;
        $display("FAIL directed_%0d result: got %h required %h (timeout %0d)",
                 i, got, tv[i].exp, to);
      end
      n_tests++;
      if (lat != tv[i].lat) begin
        n_fail++;
        $display("FAIL directed_%0d latency: got %0d required %0d", i, lat, tv[i].lat);
      end
      if (tv[i].lat > 0) begin
        n_tests++;
        if (ir_hi != 0) begin
          n_fail++;
          $display("FAIL directed_%0d in_ready_busy: got %0d cycles high required 0",
                   i, ir_hi);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [EW-1:0] e;
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 24; i++) begin
      op = 5'($urandom_range(0, 15)); a = $urandom; b = $urandom; in_valid = 1'b1;
      exp_q.push_back(model(op, a, b));
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_in_ready_%0d: got %b required 1", i, in_ready);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({out_valid, got_now()} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL b2b_result_%0d: got %h required %h", i,
                 {out_valid, got_now()}, {1'b1, e});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [EW-1:0] e1, e3;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    op = ALU_XOR; a = $urandom; b = $urandom; in_valid = 1'b1;
    e1 = model(op, a, b);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      op = 5'($urandom_range(0, 15)); a = $urandom; b = $urandom;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_in_ready_%0d_%0d: got %b required 0", k, c, in_ready);
        end
        n_tests++;
        if ({out_valid, got_now()} !== {1'b1, e1}) begin
          n_fail++;
          $display("FAIL bp_hold_%0d_%0d: got %h required %h", k, c,
                   {out_valid, got_now()}, {1'b1, e1});
        end
        @(posedge clk); #1;
      end
    end
    e3 = model(op, a, b);
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b required 1", in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({out_valid, got_now()} !== {1'b1, e3}) begin
      n_fail++;
      $display("FAIL bp_replace: got %h required %h", {out_valid, got_now()}, {1'b1, e3});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got out_valid %b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mulu;
    logic [EW-1:0] got;
    int lat, ir_hi;
    bit to, seen;
    run_op(ALU_ADDU, 32'd5, 32'd6, got, lat, ir_hi, to);
    op = ALU_MULU; a = $urandom | 32'h1; b = $urandom | 32'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, got_now()} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h required 0", {out_valid, got_now()});
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_in_ready: got %b required 1", in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_result: got out_valid seen %b required 0", seen);
    end
    @(posedge clk); #1;
    run_op(ALU_DIVU, 32'd100, 32'd7, got, lat, ir_hi, to);
    n_tests++;
    if (got !== pk(32'd2, 0, 0, 0, 0, 32'd14) || to || lat != 33) begin
      n_fail++;
      $display("FAIL midreset_next_op: got %h lat %0d required %h lat 33",
               got, lat, pk(32'd2, 0, 0, 0, 0, 32'd14));
    end
  endtask

  task automatic test_random;
    logic [EW-1:0] e;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (cyc < 750) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        op        = rand_op();
        a         = $urandom;
        b         = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_unexpected: got %h required no result", got_now());
        end else begin
          e = exp_q.pop_front();
          if (got_now() !== e) begin
            n_fail++;
            $display("FAIL rand_result: got %h required %h", got_now(), e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(op, a, b));
      @(posedge clk); #1;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: got %0d pending required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mulu();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
